// File: rtl/debug_jtag_pkg.sv
// Shared types and constants for the virtual-JTAG scan master.
package debug_jtag_pkg;

    localparam int DEFAULT_DR_WIDTH = 38;
    localparam int DEFAULT_IR_WIDTH = 2;

    // Virtual IR codes understood by the debug slave
    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RESP
    } scan_state_t;

    // clk cycles in one full tck period
    function automatic int tck_period(input int div);
        return 2 * div;
    endfunction

endpackage

// File: rtl/debug_jtag_scan_master_if.sv
// Command/response handshake between a requester and the scan master.
interface debug_jtag_scan_master_if
    import debug_jtag_pkg::*;
#(
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = DEFAULT_IR_WIDTH
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic                cmd_ir_only;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    // requester side
    modport master (
        output cmd_valid, cmd_ir, cmd_ir_only, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );

    // scan master side
    modport slave (
        input  cmd_valid, cmd_ir, cmd_ir_only, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );
endinterface

// File: rtl/jtag_tck_gen.sv
// Test-clock divider: tck low for TCK_DIV clk, then high for TCK_DIV clk.
// Always restarts at the start of a low half when run goes high, so every
// scan phase begins on a period boundary.
module jtag_tck_gen
    import debug_jtag_pkg::*;
#(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,          // next-cycle enable (controller not idle next cycle)
    output logic tck,
    output logic rise,         // this cycle is the first high cycle of tck
    output logic period_end    // this cycle is the last cycle of the period
);
    localparam int T    = tck_period(TCK_DIV);
    localparam int PH_W = $clog2(T);

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_nxt;
    logic            running;

    // Phase advance; held at zero while stopped and on the first enabled cycle
    always_comb begin
        ph_nxt = '0;
        if (run && running) begin
            ph_nxt = (ph == PH_W'(T - 1)) ? '0 : ph + 1'b1;
        end
    end

    // Phase counter and registered tck
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running <= 1'b0;
            ph      <= '0;
            tck     <= 1'b0;
        end else begin
            running <= run;
            ph      <= ph_nxt;
            tck     <= run && (ph_nxt >= PH_W'(TCK_DIV));
        end
    end

    assign rise       = running && (ph == PH_W'(TCK_DIV));
    assign period_end = running && (ph == PH_W'(T - 1));

endmodule

// File: rtl/debug_jtag_scan_master.sv
// Host-side virtual-JTAG scan master: runs one IR update and an optional
// DR capture/shift/update on the vji_* nets, then returns captured tdo.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | tck parked low, rti high, waiting for a command
// UIR     | one tck period, IR presented, slave status IR sampled
// CDR     | one tck period, capture-DR strobe
// SDR     | DR_WIDTH tck periods, shift tdi out / tdo in, LSB first
// UDR     | one tck period, update-DR strobe, then result latched
// RESP    | response held until rsp_ready
module debug_jtag_scan_master
    import debug_jtag_pkg::*;
#(
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    debug_jtag_scan_master_if.slave  bus,
    output logic [IR_WIDTH-1:0]      vji_ir_in,
    input  logic [IR_WIDTH-1:0]      vji_ir_out,
    output logic                     vji_tck,
    output logic                     vji_tdi,
    input  logic                     vji_tdo,
    output logic                     vji_rti,
    output logic                     vji_uir,
    output logic                     vji_cdr,
    output logic                     vji_sdr,
    output logic                     vji_udr
);
    localparam int CNT_W = $clog2(DR_WIDTH + 1);

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] sr_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_nxt;
    logic                ir_only;
    logic                accept;
    logic                tck_run;
    logic                tck_rise;
    logic                tck_period_end;

    assign bus.cmd_ready = (state == ST_IDLE);
    assign accept        = bus.cmd_valid && (state == ST_IDLE);

    // Outputs are registered from state_nxt, so tck must know about the
    // upcoming state as well to stay aligned with the strobes.
    assign tck_run = (state_nxt != ST_IDLE);

    jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (tck_run),
        .tck        (vji_tck),
        .rise       (tck_rise),
        .period_end (tck_period_end)
    );

    // Shift register and rise counter next values
    always_comb begin
        sr_nxt      = sr;
        bit_cnt_nxt = bit_cnt;
        if (accept) begin
            sr_nxt      = bus.cmd_data;
            bit_cnt_nxt = '0;
        end else if ((state == ST_SDR) && tck_rise) begin
            sr_nxt = {vji_tdo, sr[DR_WIDTH-1:1]};
            if (bit_cnt != CNT_W'(DR_WIDTH)) begin
                bit_cnt_nxt = bit_cnt + 1'b1;
            end
        end
    end

    // Next-state decode; phases advance only on tck period boundaries.
    // SDR exit looks at bit_cnt_nxt because with TCK_DIV=1 the last rise
    // and the period end fall on the same clk cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.cmd_valid) state_nxt = ST_UIR;
            ST_UIR:  if (tck_period_end) state_nxt = ir_only ? ST_RESP : ST_CDR;
            ST_CDR:  if (tck_period_end) state_nxt = ST_SDR;
            ST_SDR:  if (tck_period_end && (bit_cnt_nxt == CNT_W'(DR_WIDTH))) state_nxt = ST_UDR;
            ST_UDR:  if (tck_period_end) state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, shift register, counter and command latches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            ir_only   <= 1'b0;
            vji_ir_in <= '0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (accept) begin
                ir_only   <= bus.cmd_ir_only;
                vji_ir_in <= bus.cmd_ir;
            end
        end
    end

    // Registered state strobes, aligned with the state they describe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vji_rti <= 1'b1;
            vji_uir <= 1'b0;
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b0;
            vji_udr <= 1'b0;
        end else begin
            vji_rti <= (state_nxt == ST_IDLE);
            vji_uir <= (state_nxt == ST_UIR);
            vji_cdr <= (state_nxt == ST_CDR);
            vji_sdr <= (state_nxt == ST_SDR);
            vji_udr <= (state_nxt == ST_UDR);
        end
    end

    // tdi changes only at period boundaries so it is stable across the rise;
    // sr_nxt covers the TCK_DIV=1 case where the shift lands on that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vji_tdi <= 1'b0;
        end else if (tck_period_end) begin
            vji_tdi <= (state_nxt == ST_SDR) ? sr_nxt[0] : 1'b0;
        end
    end

    // Response capture and valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_ir_out <= '0;
        end else begin
            bus.rsp_valid <= (state_nxt == ST_RESP);
            if ((state == ST_UIR) && tck_rise) begin
                bus.rsp_ir_out <= vji_ir_out;
            end
            if ((state == ST_UDR) && (state_nxt == ST_RESP)) begin
                bus.rsp_data <= sr;
            end
        end
    end

endmodule

// File: tb/tb_debug_jtag_scan_master.sv
// Bench for debug_jtag_scan_master: default build (38-bit DR, TCK_DIV=2)
// plus a small build (4-bit DR, TCK_DIV=1) in loopback.
module tb_debug_jtag_scan_master;
    import debug_jtag_pkg::*;

    localparam int DRA = 38;
    localparam int TDA = 2;
    localparam int TA  = 2 * TDA;
    localparam int DRB = 4;
    localparam int TDB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    debug_jtag_scan_master_if #(.DR_WIDTH(DRA), .IR_WIDTH(2)) bus_a ();
    debug_jtag_scan_master_if #(.DR_WIDTH(DRB), .IR_WIDTH(2)) bus_b ();

    logic [1:0] ir_in_a, ir_out_a, ir_in_b, ir_out_b;
    logic tck_a, tdi_a, tdo_a, rti_a, uir_a, cdr_a, sdr_a, udr_a;
    logic tck_b, tdi_b, tdo_b, rti_b, uir_b, cdr_b, sdr_b, udr_b;

    debug_jtag_scan_master #(.DR_WIDTH(DRA), .IR_WIDTH(2), .TCK_DIV(TDA)) u_dut_a (
        .clk(clk), .reset_n(rst_a), .bus(bus_a),
        .vji_ir_in(ir_in_a), .vji_ir_out(ir_out_a), .vji_tck(tck_a), .vji_tdi(tdi_a),
        .vji_tdo(tdo_a), .vji_rti(rti_a), .vji_uir(uir_a), .vji_cdr(cdr_a),
        .vji_sdr(sdr_a), .vji_udr(udr_a)
    );

    debug_jtag_scan_master #(.DR_WIDTH(DRB), .IR_WIDTH(2), .TCK_DIV(TDB)) u_dut_b (
        .clk(clk), .reset_n(rst_b), .bus(bus_b),
        .vji_ir_in(ir_in_b), .vji_ir_out(ir_out_b), .vji_tck(tck_b), .vji_tdi(tdi_b),
        .vji_tdo(tdo_b), .vji_rti(rti_b), .vji_uir(uir_b), .vji_cdr(cdr_b),
        .vji_sdr(sdr_b), .vji_udr(udr_b)
    );

    assign tdo_b = tdi_b;

    int total = 0;
    int bad   = 0;

    // observation state for DUT A
    int n_uir, n_cdr, n_udr, overlap_err, order_err, tdi_err, last_p, ridx;
    bit rise_pend;
    int tdo_mode;                 // 0 loopback, 1 constant one, 2 preset bit vector
    logic [DRA-1:0] cur_data, tdo_vec, last_rsp;

    always_comb begin
        tdo_a = 1'b0;
        case (tdo_mode)
            0:       tdo_a = tdi_a;
            1:       tdo_a = 1'b1;
            default: if (ridx < DRA) tdo_a = tdo_vec[ridx];
        endcase
    end

    // ridx = index of the current SDR period (rises completed so far)
    always @(posedge tck_a) if (sdr_a) rise_pend = 1'b1;
    always @(negedge tck_a) if (rise_pend) begin ridx++; rise_pend = 1'b0; end

    always @(negedge clk) begin
        int p;
        n_uir += int'(uir_a);
        n_cdr += int'(cdr_a);
        n_udr += int'(udr_a);
        if (int'(uir_a) + int'(cdr_a) + int'(sdr_a) + int'(udr_a) > 1) overlap_err++;
        p = uir_a ? 1 : cdr_a ? 2 : sdr_a ? 3 : udr_a ? 4 : 0;
        if (p != 0) begin
            if (p < last_p) order_err++;
            last_p = p;
        end
        if (sdr_a && (ridx < DRA) && (tdi_a !== cur_data[ridx])) tdi_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic int exp_lat(input logic ir_only, input int dr, input int t);
        return 1 + (ir_only ? 1 : 3 + dr) * t;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon(input logic [DRA-1:0] data);
        n_uir = 0; n_cdr = 0; n_udr = 0;
        overlap_err = 0; order_err = 0; tdi_err = 0;
        last_p = 0; ridx = 0; rise_pend = 1'b0;
        cur_data = data;
    endtask

    task automatic start_a(input logic [1:0] ir, input logic ir_only, input logic [DRA-1:0] data);
        @(posedge clk); #1;
        bus_a.cmd_ir = ir; bus_a.cmd_ir_only = ir_only; bus_a.cmd_data = data;
        bus_a.cmd_valid = 1'b1;
        clear_mon(data);
        @(posedge clk); #1;
        bus_a.cmd_valid = 1'b0;
    endtask

    // called just after the accept edge; returns cycle index of first rsp_valid
    task automatic wait_rsp_a(output int lat);
        lat = 1;
        while (lat < 1000) begin
            @(negedge clk);
            if (bus_a.rsp_valid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic release_a();
        @(posedge clk); #1 bus_a.rsp_ready = 1'b1;
        @(posedge clk); #1 bus_a.rsp_ready = 1'b0;
    endtask

    task automatic check_scan(input string pfx, input int lat, input logic ir_only,
                              input logic [1:0] ir, input logic [1:0] irout,
                              input logic [DRA-1:0] exp_data);
        check({pfx, "_latency"}, lat, exp_lat(ir_only, DRA, TA));
        check({pfx, "_rsp_data"}, bus_a.rsp_data, exp_data);
        check({pfx, "_rsp_ir_out"}, bus_a.rsp_ir_out, irout);
        check({pfx, "_ir_in"}, ir_in_a, ir);
        check({pfx, "_uir_cycles"}, n_uir, TA);
        check({pfx, "_cdr_cycles"}, n_cdr, ir_only ? 0 : TA);
        check({pfx, "_sdr_rises"}, ridx, ir_only ? 0 : DRA);
        check({pfx, "_udr_cycles"}, n_udr, ir_only ? 0 : TA);
        check({pfx, "_overlap"}, overlap_err, 0);
        check({pfx, "_order"}, order_err, 0);
        check({pfx, "_tdi_seq"}, tdi_err, 0);
    endtask

    task automatic run_scan_a(input string pfx, input logic [1:0] ir, input logic ir_only,
                              input logic [DRA-1:0] data, input int mode,
                              input logic [DRA-1:0] tbits, input logic [1:0] irout);
        int lat;
        logic [DRA-1:0] exp_data;
        tdo_mode = mode; tdo_vec = tbits; ir_out_a = irout;
        start_a(ir, ir_only, data);
        wait_rsp_a(lat);
        if (ir_only)        exp_data = last_rsp;
        else if (mode == 0) exp_data = data;
        else if (mode == 1) exp_data = '1;
        else                exp_data = tbits;
        check_scan(pfx, lat, ir_only, ir, irout, exp_data);
        last_rsp = exp_data;
        release_a();
        @(negedge clk);
        check({pfx, "_idle_tck_rti"}, {tck_a, rti_a, bus_a.cmd_ready}, 3'b011);
    endtask

    logic [1:0] ir_tab [4];

    initial begin
        int lat, k;
        logic [DRA-1:0] d, t, d2;
        logic [1:0] ir;
        logic io, stable, seen;
        logic [3:0] tck_pat;

        ir_tab[0] = IR_OCIMEM; ir_tab[1] = IR_TRACEMEM;
        ir_tab[2] = IR_BREAK;  ir_tab[3] = IR_TRACECTRL;
        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_ir = '0; bus_a.cmd_ir_only = 1'b0;
        bus_a.cmd_data = '0; bus_a.rsp_ready = 1'b0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_ir = '0; bus_b.cmd_ir_only = 1'b0;
        bus_b.cmd_data = '0; bus_b.rsp_ready = 1'b0;
        ir_out_a = 2'b00; ir_out_b = 2'b00;
        tdo_mode = 0; tdo_vec = '0; last_rsp = '0;
        clear_mon('0);

        // reset values
        repeat (2) @(negedge clk);
        check("rst_tck_tdi_strobes", {tck_a, tdi_a, uir_a, cdr_a, sdr_a, udr_a}, 6'b0);
        check("rst_rti_ready", {rti_a, bus_a.cmd_ready}, 2'b11);
        check("rst_ir_in", ir_in_a, 2'b00);
        check("rst_rsp", {bus_a.rsp_valid, bus_a.rsp_ir_out}, 3'b000);
        check("rst_rsp_data", bus_a.rsp_data, 38'h0);
        check("rst_b", {bus_b.rsp_valid, bus_b.cmd_ready, tck_b}, 3'b010);
        @(posedge clk); #1 rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {tck_a, rti_a, bus_a.cmd_ready, bus_a.rsp_valid}, 4'b0110);

        // directed scans
        run_scan_a("ironly", IR_BREAK, 1'b1, 38'h0, 0, '0, 2'b01);
        run_scan_a("loopback", IR_OCIMEM, 1'b0, 38'h15_5555_5555, 0, '0, 2'b11);
        run_scan_a("tdo_one", IR_TRACEMEM, 1'b0, 38'h0, 1, '0, 2'b10);

        // randomized scans against the preset tdo vector
        for (int i = 0; i < 4; i++) begin
            d  = {$urandom, $urandom};
            t  = {$urandom, $urandom};
            ir = ir_tab[$urandom_range(0, 3)];
            io = (i == 2);
            run_scan_a($sformatf("rand%0d", i), ir, io, d, 2, t, 2'($urandom_range(0, 3)));
        end

        // back-pressure: response held, second command ignored until idle
        d = {$urandom, $urandom};
        t = {$urandom, $urandom};
        tdo_mode = 2; tdo_vec = t; ir_out_a = 2'b00;
        start_a(IR_TRACEMEM, 1'b0, d);
        wait_rsp_a(lat);
        check_scan("bp_first", lat, 1'b0, IR_TRACEMEM, 2'b00, t);
        last_rsp = t;
        stable = 1'b1;
        d2 = {$urandom, $urandom};
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                bus_a.cmd_ir = IR_TRACECTRL; bus_a.cmd_ir_only = 1'b1;
                bus_a.cmd_data = d2; bus_a.cmd_valid = 1'b1;
                ir_out_a = 2'b10;
            end
            @(negedge clk);
            if (!(bus_a.rsp_valid === 1'b1 && bus_a.rsp_data === t && bus_a.cmd_ready === 1'b0
                  && bus_a.rsp_ir_out === 2'b00 && ir_in_a === IR_TRACEMEM && rti_a === 1'b0
                  && {uir_a, cdr_a, sdr_a, udr_a} === 4'b0))
                stable = 1'b0;
        end
        check("bp_hold_stable", stable, 1'b1);
        @(posedge clk); #1 bus_a.rsp_ready = 1'b1;
        @(posedge clk); #1 bus_a.rsp_ready = 1'b0;
        clear_mon(d2);
        @(negedge clk);
        check("bp_idle_after_ready", {bus_a.cmd_ready, bus_a.rsp_valid}, 2'b10);
        @(posedge clk); #1 bus_a.cmd_valid = 1'b0;
        wait_rsp_a(lat);
        check_scan("bp_second", lat, 1'b1, IR_TRACECTRL, 2'b10, last_rsp);
        release_a();

        // reset in the middle of SDR
        tdo_mode = 0;
        start_a(IR_OCIMEM, 1'b0, {$urandom, $urandom});
        k = 0;
        while (ridx < 10 && k < 1000) begin @(negedge clk); k++; end
        check("rst_mid_reached_sdr", {sdr_a, 1'(ridx >= 10)}, 2'b11);
        @(posedge clk); #1 rst_a = 1'b0; #1;
        check("rst_mid_outputs", {tck_a, uir_a, cdr_a, sdr_a, udr_a, bus_a.rsp_valid}, 6'b0);
        check("rst_mid_rti_ready", {rti_a, bus_a.cmd_ready}, 2'b11);
        check("rst_mid_rsp_data", bus_a.rsp_data, 38'h0);
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1;
        last_rsp = '0;
        seen = 1'b0;
        repeat (200) begin @(negedge clk); seen = seen | bus_a.rsp_valid | tck_a; end
        check("rst_mid_no_udr", n_udr, 0);
        check("rst_mid_stays_idle", seen, 1'b0);

        // recovery scan after the abort
        run_scan_a("recover", IR_BREAK, 1'b0, {$urandom, $urandom}, 0, '0, 2'b01);

        // small build: TCK_DIV=1, DR_WIDTH=4, loopback
        @(posedge clk); #1;
        bus_b.cmd_ir = IR_OCIMEM; bus_b.cmd_ir_only = 1'b0; bus_b.cmd_data = 4'hA;
        bus_b.cmd_valid = 1'b1;
        @(posedge clk); #1 bus_b.cmd_valid = 1'b0;
        lat = 1; tck_pat = '0;
        while (lat < 200) begin
            @(negedge clk);
            if (lat <= 4) tck_pat[lat-1] = tck_b;
            if (bus_b.rsp_valid) break;
            @(posedge clk);
            lat++;
        end
        check("b_tck_pattern", tck_pat, 4'b1010);
        check("b_latency", lat, exp_lat(1'b0, DRB, 2 * TDB));
        check("b_rsp_data", bus_b.rsp_data, 4'hA);
        @(posedge clk); #1 bus_b.rsp_ready = 1'b1;
        @(posedge clk); #1 bus_b.rsp_ready = 1'b0;
        @(negedge clk);
        check("b_idle", {bus_b.cmd_ready, bus_b.rsp_valid, tck_b, rti_b}, 4'b1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_jtag_scan_master.md
Name: debug_jtag_scan_master

Overview:
- Host-side driver of the 2-bit-IR virtual-JTAG debug interface. It generates the tck/tdi/state-strobe sequence that the debug slave's tck and sysclk halves consume, and collects tdo.
- Lets on-chip logic (bring-up sequencer, BIST, scripted debug) issue IR + DR scans to the Nios II debug slave without an external JTAG cable.
- Sits between a command/response requester and the vji_* nets of the debug slave wrapper.

Parameters:
- DR_WIDTH, 38: data-register scan length in bits; must be >= 2.
- IR_WIDTH, 2: virtual IR width.
- TCK_DIV, 2: clk cycles per tck half-period; must be >= 1. T = 2*TCK_DIV clk cycles per tck period.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle; accept happens when cmd_valid && cmd_ready.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_ir_only  in  1  1 = IR scan only, no DR scan.
- cmd_data  in  DR_WIDTH  DR value to shift in, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DR_WIDTH  captured tdo bits, first bit in at [0].
- rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during UIR.
- vji_ir_in  out  IR_WIDTH  IR value presented to slave.
- vji_ir_out  in  IR_WIDTH  slave status IR.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_rti  out  1  run-test-idle indicator.
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual state strobes.

Behaviour:
- Reset values:
  - state = IDLE, vji_tck = 0, vji_tdi = 0.
  - All strobes = 0, vji_rti = 1, vji_ir_in = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_ir_out = 0.
  - cmd_ready = 1, since it is decoded as state == IDLE.
- All outputs are registered except cmd_ready.
- States: IDLE, UIR, CDR, SDR, UDR, RESP.
- Each phase lasts whole tck periods. Within a period, tck is low for TCK_DIV clk, then high for TCK_DIV clk.
  - rise = clk cycle where tck goes 0->1.
  - A period ends on the clk cycle before tck returns low.
- In IDLE, tck is held low and vji_rti = 1. Outside IDLE, vji_rti = 0.
- Accept at cycle 0:
  - latch cmd_ir into vji_ir_in (held until the next accept);
  - latch cmd_data into the shift register;
  - move to UIR at cycle 1.
- UIR, 1 period: vji_uir = 1. rsp_ir_out samples vji_ir_out on the rise. Next state is RESP if cmd_ir_only, else CDR.
- CDR, 1 period: vji_cdr = 1.
- SDR, DR_WIDTH periods: vji_sdr = 1.
  - vji_tdi = sr[0], valid for the whole period.
  - On each rise: sr <= {vji_tdo, sr[DR_WIDTH-1:1]}.
  - A bit counter counts exactly DR_WIDTH rises, then the FSM goes to UDR.
  - The counter width is clog2(DR_WIDTH+1); no wrap.
- UDR, 1 period: vji_udr = 1. Then rsp_data <= sr and the FSM goes to RESP.
- RESP:
  - rsp_valid = 1, held stable until rsp_ready is sampled high.
  - Then go to IDLE; cmd_ready rises the next cycle.
- Latency, accept to first rsp_valid:
  - full scan: 1 + (3 + DR_WIDTH)*T clk cycles, i.e. 165 at defaults;
  - IR-only: 1 + T, i.e. 5.
- Exactly one strobe is high at any time outside IDLE/RESP. Strobes never overlap.
- A cmd_valid seen outside IDLE is ignored; no queueing.
- rsp_ready high while rsp_valid is low has no effect.
- Asserting reset_n low mid-scan:
  - immediately forces reset values;
  - no UDR is ever emitted for an aborted scan, so the slave takes no action.

Decomposition:
- Package debug_jtag_pkg holds:
  - the state enum;
  - IR code constants: 2'd0 OCIMEM, 2'd1 TRACEMEM, 2'd2 BREAK, 2'd3 TRACECTRL;
  - the default DR_WIDTH (38).
- One sub-module, jtag_tck_gen:
  - a TCK_DIV divider;
  - outputs vji_tck, a rise pulse and a period_end pulse;
  - enabled when state != IDLE;
  - restarts low on enable.

Test Plan:
- IR-only: cmd_ir=2'd2, cmd_ir_only=1, vji_ir_out=2'b01 -> exactly 1 uir period, no cdr/sdr/udr; rsp_valid at cycle 5 with rsp_ir_out=2'b01.
- Loopback (tdo fed from tdi): cmd_data=38'h15_5555_5555 -> uir, cdr, 38 sdr rises, udr in order, no strobe overlap; rsp_data=38'h15_5555_5555 at cycle 165.
- Constant tdo=1, cmd_data=0 -> vji_tdi stays 0 throughout SDR; rsp_data=38'h3F_FFFF_FFFF.
- Back-pressure: rsp_ready=0 for 20 cycles -> rsp_valid and rsp_data stable, cmd_ready=0; a second cmd_valid during this window is ignored. rsp_ready=1 -> IDLE next cycle, then the second command is accepted.
- Reset mid-SDR (after 10 rises): reset_n low -> same cycle tck=0, all strobes 0, rti=1, rsp_valid=0; udr never asserted.
- TCK_DIV=1, DR_WIDTH=4: cmd_data=4'hA with loopback -> tck period 2 clk, rsp_data=4'hA at cycle 1+7*2=15.
